// File: rtl/hazard_stall_unit.sv
// Decode-stage stall detector: register hazards against NSTG downstream stages plus an MDU busy tracker.
// Optional stall performance counters are built when HAZARD_STALL_PERF_EN is defined.

module hazard_stage_cmp #(
  parameter int RW = 5,
  parameter int TW = 3
) (
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic [TW-1:0] tuse_rs,
  input  logic [TW-1:0] tuse_rt,
  input  logic [RW-1:0] dst,
  input  logic [TW-1:0] tnew,
  output logic          hit
);
  logic hit_rs, hit_rt;

  // An all-ones Tuse can never be below a TW-wide Tnew, so unused sources drop out naturally.
  assign hit_rs = (rs != '0) && (rs == dst) && (tuse_rs < tnew);
  assign hit_rt = (rt != '0) && (rt == dst) && (tuse_rt < tnew);
  assign hit    = hit_rs | hit_rt;
endmodule

module hazard_stall_unit #(
  parameter int NSTG        = 2,
  parameter int RW          = 5,
  parameter int TW          = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RW-1:0]      D_rs,
  input  logic [RW-1:0]      D_rt,
  input  logic [TW-1:0]      D_tuse_rs,
  input  logic [TW-1:0]      D_tuse_rt,
  input  logic               D_md_use,
  input  logic [NSTG*RW-1:0] stg_dst,
  input  logic [NSTG*TW-1:0] stg_tnew,
  input  logic               md_start,
  input  logic               md_is_div,
  output logic               stall,
  output logic               E_flush,
  output logic               md_busy
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        md_stall_cycles
`endif
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  logic [NSTG-1:0] hit;
  logic            reg_stall;
  logic            md_stall;
  logic [CW-1:0]   cnt;

  for (genvar i = 0; i < NSTG; i++) begin : g_stg
    hazard_stage_cmp #(.RW(RW), .TW(TW)) u_cmp (
      .rs      (D_rs),
      .rt      (D_rt),
      .tuse_rs (D_tuse_rs),
      .tuse_rt (D_tuse_rt),
      .dst     (stg_dst[i*RW +: RW]),
      .tnew    (stg_tnew[i*TW +: TW]),
      .hit     (hit[i])
    );
  end

  assign reg_stall = |hit;

  // The start cycle itself counts as busy, so the counter only covers the remaining cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (md_start)   cnt <= md_is_div ? DIV_LOAD : MULT_LOAD;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign md_busy  = md_start | (cnt != '0);
  assign md_stall = D_md_use & md_busy;
  assign stall    = reg_stall | md_stall;
  assign E_flush  = stall;

`ifdef HAZARD_STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall)    stall_cycles    <= stall_cycles + 32'd1;
      if (md_stall) md_stall_cycles <= md_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: literal checks plus a per-cycle time-window reference model.
module tb_hazard_stall_unit;
  localparam int NSTG = 2, RW = 5, TW = 3, MC = 5, DC = 10;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [RW-1:0] D_rs, D_rt;
  logic [TW-1:0] D_tuse_rs, D_tuse_rt;
  logic D_md_use, md_start, md_is_div;
  logic [RW-1:0] dst  [NSTG];
  logic [TW-1:0] tnew [NSTG];
  logic [NSTG*RW-1:0] stg_dst;
  logic [NSTG*TW-1:0] stg_tnew;
  logic stall, E_flush, md_busy;
`ifdef HAZARD_STALL_PERF_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    stg_dst  = '0;
    stg_tnew = '0;
    for (int i = 0; i < NSTG; i++) begin
      stg_dst[i*RW +: RW]  = dst[i];
      stg_tnew[i*TW +: TW] = tnew[i];
    end
  end

  hazard_stall_unit #(.NSTG(NSTG), .RW(RW), .TW(TW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md_use(D_md_use), .stg_dst(stg_dst), .stg_tnew(stg_tnew), .md_start(md_start),
    .md_is_div(md_is_div), .stall(stall), .E_flush(E_flush), .md_busy(md_busy)
`ifdef HAZARD_STALL_PERF_EN
    , .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a start in cycle c makes the MDU busy over cycles c .. c+len-1.
  int cyc = 0, busy_end = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_end = -1;
    else begin
      if (md_start) busy_end = cyc + (md_is_div ? DC : MC) - 1;
      cyc++;
    end
  end

  function automatic bit m_busy();
    return md_start || (cyc <= busy_end);
  endfunction

  function automatic bit m_reg();
    bit h = 1'b0;
    for (int i = 0; i < NSTG; i++) begin
      if (D_rs != 0 && D_rs == dst[i] && int'(D_tuse_rs) < int'(tnew[i])) h = 1'b1;
      if (D_rt != 0 && D_rt == dst[i] && int'(D_tuse_rt) < int'(tnew[i])) h = 1'b1;
    end
    return h;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_stall", {31'd0, stall},   {31'd0, m_reg() || (D_md_use && m_busy())});
      chk("model_flush", {31'd0, E_flush}, {31'd0, m_reg() || (D_md_use && m_busy())});
      chk("model_busy",  {31'd0, md_busy}, {31'd0, m_busy()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    D_rs = '0; D_rt = '0; D_tuse_rs = '1; D_tuse_rt = '1;
    D_md_use = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    for (int i = 0; i < NSTG; i++) begin dst[i] = '0; tnew[i] = '0; end
  endtask

  initial begin
    clear_in();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy",  {31'd0, md_busy}, 32'd0);
`ifdef HAZARD_STALL_PERF_EN
    chk("reset_perf_stall", stall_cycles, 32'd0);
    chk("reset_perf_md",    md_stall_cycles, 32'd0);
`endif
    cmp_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();

    // Load-use in E
    D_rs = 5'd8; D_tuse_rs = 3'd1; dst[0] = 5'd8; tnew[0] = 3'd2;
    @(negedge clk);
    chk("load_use_stall", {31'd0, stall}, 32'd1);
    chk("load_use_flush", {31'd0, E_flush}, 32'd1);
    step(); D_rs = 5'd0;
    @(negedge clk); chk("load_use_r0", {31'd0, stall}, 32'd0);
    step(); clear_in();

    // M-stage compare on rt
    D_rt = 5'd9; D_tuse_rt = 3'd0; dst[1] = 5'd9; tnew[1] = 3'd1;
    @(negedge clk); chk("m_stage_hit", {31'd0, stall}, 32'd1);
    step(); tnew[1] = 3'd0;
    @(negedge clk); chk("m_stage_tnew0", {31'd0, stall}, 32'd0);
    step(); tnew[1] = 3'd1; D_tuse_rt = 3'd7;
    @(negedge clk); chk("m_stage_unused", {31'd0, stall}, 32'd0);
    step(); clear_in();

    // MULT window with an MDU user in D
    D_md_use = 1'b1; md_start = 1'b1; md_is_div = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk($sformatf("mult_win%0d", k), {31'd0, stall}, (k < 5) ? 32'd1 : 32'd0);
      step();
      if (k == 0) md_start = 1'b0;
    end
    clear_in();

    // DIV then MULT restart 3 cycles later
    for (int k = 0; k < 10; k++) begin
      md_start  = (k == 0 || k == 3);
      md_is_div = (k == 0);
      @(negedge clk); chk($sformatf("div_restart%0d", k), {31'd0, md_busy}, (k < 8) ? 32'd1 : 32'd0);
      step();
    end
    clear_in();

    // Register hazard and MDU stall together
    D_md_use = 1'b1; md_start = 1'b1; D_rs = 5'd3; D_tuse_rs = 3'd0; dst[0] = 5'd3; tnew[0] = 3'd1;
    @(negedge clk); chk("both_stall", {31'd0, stall}, 32'd1);
    step(); clear_in();
    for (int k = 0; k < 6; k++) step();

    // Asynchronous reset mid-divide, at count 6
    md_start = 1'b1; md_is_div = 1'b1;
    step(); md_start = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", {31'd0, md_busy}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_async_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    D_md_use = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_busy",  {31'd0, md_busy}, 32'd0);
    step();

    // MULT window right after reset; perf counters see exactly this window
    md_start = 1'b1; md_is_div = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); chk($sformatf("mult2_win%0d", k), {31'd0, stall}, (k < 5) ? 32'd1 : 32'd0);
      step();
      if (k == 0) md_start = 1'b0;
    end
    @(negedge clk);
`ifdef HAZARD_STALL_PERF_EN
    chk("perf_stall_cycles", stall_cycles, 32'd5);
    chk("perf_md_stall_cycles", md_stall_cycles, 32'd5);
`endif
    step(); clear_in();

    // Pseudo-random mix checked by the model every cycle
    for (int k = 0; k < 200; k++) begin
      D_rs = RW'($urandom_range(0, 3)); D_rt = RW'($urandom_range(0, 3));
      D_tuse_rs = TW'($urandom_range(0, 7)); D_tuse_rt = TW'($urandom_range(0, 7));
      for (int i = 0; i < NSTG; i++) begin
        dst[i] = RW'($urandom_range(0, 3)); tnew[i] = TW'($urandom_range(0, 7));
      end
      D_md_use  = ($urandom_range(0, 1) == 1);
      md_start  = ($urandom_range(0, 7) == 0);
      md_is_div = ($urandom_range(0, 1) == 1);
      step();
    end
    clear_in();
    step();
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
